wfifo_wr_arbiter: RTL and testbench

- Round-robin arbiter sharing the single write port of the asynchronous FIFO write domain between NREQ requesters.
- Grants one requester at a time for a burst of up to MAXBURST words.
- Drives winc/wdata into the write-pointer/full logic and stalls on wfull so that no write is ever dropped.
- Sits entirely in the wclk domain, in front of the FIFO write port.

---
 rtl/wfifo_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_wfifo_wr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between NREQ requesters in bursts of up to MAXBURST words.
// Optional statistics counters are enabled with `define WFIFO_WR_ARB_STATS_EN.
module wfifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata
`ifdef WFIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]           wr_word_cnt,
  output logic [15:0]           full_stall_cnt
`endif
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]   owner_inc;
  logic [BW-1:0]   beat_cnt, beat_cnt_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   scan;
  logic            owner_valid;

  // Rotating priority search starting at rr_ptr, wrapping by explicit compare so non-power-of-2 NREQ works
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    scan       = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && req_valid[scan]) begin
        pick_found = 1'b1;
        pick_idx   = scan;
      end
      scan = (scan == PW'(NREQ - 1)) ? '0 : scan + 1'b1;
    end
  end

  assign owner_valid = req_valid[owner];
  assign owner_inc   = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign busy        = (state == BUSY);

  // Write strobe stays combinational on wfull so a word is never pushed into a full FIFO; reset cycle writes nothing
  assign winc  = busy & ~wrst & owner_valid & ~wfull;
  assign wdata = busy ? req_data[owner*DSIZE +: DSIZE] : '0;

  always_comb begin
    req_ready = '0;
    if (busy && !wrst && !wfull) req_ready[owner] = 1'b1;
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    gnt_nxt      = gnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt    = BUSY;
          owner_nxt    = pick_idx;
          beat_cnt_nxt = '0;
          gnt_nxt      = NREQ'(1) << pick_idx;
        end
      end
      BUSY: begin
        // A full FIFO freezes everything, including a requester that has dropped valid
        if (!wfull) begin
          if (owner_valid) beat_cnt_nxt = beat_cnt + 1'b1;
          if (!owner_valid || beat_cnt == BW'(MAXBURST - 1)) begin
            state_nxt  = IDLE;
            gnt_nxt    = '0;
            rr_ptr_nxt = owner_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      gnt      <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      gnt      <= gnt_nxt;
    end
  end

`ifdef WFIFO_WR_ARB_STATS_EN
  // Saturating event counters for words written and cycles lost to a full FIFO
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wr_word_cnt    <= '0;
      full_stall_cnt <= '0;
    end else begin
      if (winc && wr_word_cnt != 16'hFFFF) wr_word_cnt <= wr_word_cnt + 16'd1;
      if (busy && owner_valid && wfull && full_stall_cnt != 16'hFFFF)
        full_stall_cnt <= full_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wfifo_wr_arbiter.sv
// Bench for wfifo_wr_arbiter: a 4-requester/4-beat instance and a 2-requester/1-beat instance checked against a behavioural model.
// Statistics outputs are checked when WFIFO_WR_ARB_STATS_EN is defined.
module tb_wfifo_wr_arbiter;

  typedef struct packed {
    int busy;
    int owner;
    int ptr;
    int beats;
    int words;
    int stalls;
    int xfer;
  } model_t;

  logic wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic        a_wrst, a_wfull, a_busy, a_winc;
  logic [3:0]  a_req_valid, a_req_ready, a_gnt;
  logic [31:0] a_req_data;
  logic [7:0]  a_wdata;

  logic        b_wrst, b_wfull, b_busy, b_winc;
  logic [1:0]  b_req_valid, b_req_ready, b_gnt;
  logic [15:0] b_req_data;
  logic [7:0]  b_wdata;

`ifdef WFIFO_WR_ARB_STATS_EN
  logic [15:0] a_wr_word_cnt, a_full_stall_cnt, b_wr_word_cnt, b_full_stall_cnt;
`endif

  wfifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAXBURST(4)) dut_a (
    .wclk(wclk), .wrst(a_wrst), .req_valid(a_req_valid), .req_data(a_req_data),
    .req_ready(a_req_ready), .gnt(a_gnt), .busy(a_busy), .wfull(a_wfull),
    .winc(a_winc), .wdata(a_wdata)
`ifdef WFIFO_WR_ARB_STATS_EN
    , .wr_word_cnt(a_wr_word_cnt), .full_stall_cnt(a_full_stall_cnt)
`endif
  );

  wfifo_wr_arbiter #(.NREQ(2), .DSIZE(8), .MAXBURST(1)) dut_b (
    .wclk(wclk), .wrst(b_wrst), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_ready(b_req_ready), .gnt(b_gnt), .busy(b_busy), .wfull(b_wfull),
    .winc(b_winc), .wdata(b_wdata)
`ifdef WFIFO_WR_ARB_STATS_EN
    , .wr_word_cnt(b_wr_word_cnt), .full_stall_cnt(b_full_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  model_t ma = '0;
  model_t mb = '0;
  logic [7:0] a_words[$];
  logic [3:0] a_gnt_hist[$];
  logic [3:0] a_prev_gnt = '0;
  logic [1:0] b_gnt_hist[$];
  logic       b_winc_hist[$];

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Behavioural reference: one clock of the arbiter's rules applied to the abstract state
  function automatic model_t modelNext(input model_t m, input int n, input int maxb,
                                       input logic rst, input logic [7:0] valid, input logic full);
    model_t r;
    logic found;
    int idx;
    r = m;
    r.xfer = -1;
    found = 1'b0;
    if (rst) begin
      r = '0;
      r.xfer = -1;
    end else if (m.busy == 0) begin
      for (int k = 0; k < n; k++) begin
        idx = (m.ptr + k) % n;
        if (!found && valid[idx]) begin
          found = 1'b1;
          r.busy = 1;
          r.owner = idx;
          r.beats = 0;
        end
      end
    end else if (full) begin
      if (valid[m.owner]) r.stalls = sat16(m.stalls + 1);
    end else if (!valid[m.owner]) begin
      r.busy = 0;
      r.ptr = (m.owner + 1) % n;
    end else begin
      r.xfer = m.owner;
      r.words = sat16(m.words + 1);
      r.beats = m.beats + 1;
      if (r.beats == maxb) begin
        r.busy = 0;
        r.ptr = (m.owner + 1) % n;
      end
    end
    return r;
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] eg_a, er_a;
    logic [1:0] eg_b, er_b;
    logic       ew_a, ew_b;
    logic [7:0] ed_a, ed_b;
    eg_a = (ma.busy != 0) ? 4'(1 << ma.owner) : 4'b0;
    ew_a = (ma.busy != 0) && !a_wrst && a_req_valid[ma.owner] && !a_wfull;
    er_a = ((ma.busy != 0) && !a_wrst && !a_wfull) ? 4'(1 << ma.owner) : 4'b0;
    ed_a = (ma.busy != 0) ? a_req_data[ma.owner*8 +: 8] : 8'h00;
    checkEq("a_gnt", 32'(a_gnt), 32'(eg_a));
    checkEq("a_busy", 32'(a_busy), 32'(ma.busy != 0));
    checkEq("a_winc", 32'(a_winc), 32'(ew_a));
    checkEq("a_req_ready", 32'(a_req_ready), 32'(er_a));
    checkEq("a_wdata", 32'(a_wdata), 32'(ed_a));
    eg_b = (mb.busy != 0) ? 2'(1 << mb.owner) : 2'b0;
    ew_b = (mb.busy != 0) && !b_wrst && b_req_valid[mb.owner] && !b_wfull;
    er_b = ((mb.busy != 0) && !b_wrst && !b_wfull) ? 2'(1 << mb.owner) : 2'b0;
    ed_b = (mb.busy != 0) ? b_req_data[mb.owner*8 +: 8] : 8'h00;
    checkEq("b_gnt", 32'(b_gnt), 32'(eg_b));
    checkEq("b_busy", 32'(b_busy), 32'(mb.busy != 0));
    checkEq("b_winc", 32'(b_winc), 32'(ew_b));
    checkEq("b_req_ready", 32'(b_req_ready), 32'(er_b));
    checkEq("b_wdata", 32'(b_wdata), 32'(ed_b));
`ifdef WFIFO_WR_ARB_STATS_EN
    checkEq("a_wr_word_cnt", 32'(a_wr_word_cnt), 32'(ma.words));
    checkEq("a_full_stall_cnt", 32'(a_full_stall_cnt), 32'(ma.stalls));
    checkEq("b_wr_word_cnt", 32'(b_wr_word_cnt), 32'(mb.words));
    checkEq("b_full_stall_cnt", 32'(b_full_stall_cnt), 32'(mb.stalls));
`endif
    if (a_winc) a_words.push_back(a_wdata);
    if (a_gnt != 4'b0 && a_gnt != a_prev_gnt) a_gnt_hist.push_back(a_gnt);
    a_prev_gnt = a_gnt;
    if (!b_wrst && b_gnt_hist.size() < 6) begin
      b_gnt_hist.push_back(b_gnt);
      b_winc_hist.push_back(b_winc);
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge, return just after the edge
  task automatic applyStimulus();
    @(negedge wclk);
    #1;
    checkOutput();
    @(posedge wclk);
    ma = modelNext(ma, 4, 4, a_wrst, 8'(a_req_valid), a_wfull);
    mb = modelNext(mb, 2, 1, b_wrst, 8'(b_req_valid), b_wfull);
    #2;
  endtask

  task automatic resetA();
    a_wrst = 1'b1;
    applyStimulus();
    a_wrst = 1'b0;
  endtask

  initial begin
    int seq;
    int nw;
    logic [3:0] exp_gnt_seq[5];
    logic [1:0] exp_b_gnt[6];
    exp_gnt_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_b_gnt   = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

    a_wrst = 1'b1; a_req_valid = '0; a_req_data = '0; a_wfull = 1'b0;
    b_wrst = 1'b1; b_req_valid = '0; b_req_data = '0; b_wfull = 1'b0;
    applyStimulus();
    applyStimulus();
    a_wrst = 1'b0;
    b_wrst = 1'b0;
    b_req_valid = 2'b11;
    b_req_data = 16'h5AA5;

    $display("[TB] single requester, 10 words");
    seq = 0;
    for (int c = 0; c < 16; c++) begin
      a_req_valid = (seq < 10) ? 4'b0001 : 4'b0000;
      a_req_data = {24'h0, 8'(8'h10 + seq)};
      applyStimulus();
      if (ma.xfer == 0) seq++;
    end
    checkEq("t1_word_count", 32'(a_words.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      checkEq("t1_word_order", (i < a_words.size()) ? 32'(a_words[i]) : 32'h1FF, 32'(8'h10 + i));
    for (int i = 0; i < 6; i++) begin
      checkEq("b_alt_gnt", (i < b_gnt_hist.size()) ? 32'(b_gnt_hist[i]) : 32'hF, 32'(exp_b_gnt[i]));
      checkEq("b_alt_winc", (i < b_winc_hist.size()) ? 32'(b_winc_hist[i]) : 32'hF, 32'(i % 2));
    end

    $display("[TB] all requesting");
    a_req_valid = '0;
    resetA();
    a_words.delete();
    a_gnt_hist.delete();
    a_req_valid = 4'b1111;
    for (int c = 0; c < 26; c++) begin
      a_req_data = $urandom;
      applyStimulus();
    end
    for (int i = 0; i < 5; i++)
      checkEq("t2_gnt_seq", (i < a_gnt_hist.size()) ? 32'(a_gnt_hist[i]) : 32'hF, 32'(exp_gnt_seq[i]));
    checkEq("t2_words", 32'(a_words.size()), 32'd20);

    $display("[TB] full stall");
    a_req_valid = '0;
    resetA();
    a_words.delete();
    a_req_valid = 4'b0100;
    a_req_data = 32'hC3C3_C3C3;
    applyStimulus();
    applyStimulus();
    a_wfull = 1'b1;
    nw = a_words.size();
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      checkEq("t3_gnt_held", 32'(a_gnt), 32'h4);
    end
    checkEq("t3_no_write_in_stall", 32'(a_words.size()), 32'(nw));
`ifdef WFIFO_WR_ARB_STATS_EN
    checkEq("t3_full_stall_cnt", 32'(a_full_stall_cnt), 32'd5);
`endif
    a_wfull = 1'b0;
    for (int c = 0; c < 3; c++) applyStimulus();
    a_req_valid = '0;
    applyStimulus();
    checkEq("t3_burst_words", 32'(a_words.size()), 32'd4);

    $display("[TB] early release");
    resetA();
    a_words.delete();
    a_req_valid = 4'b1000;
    a_req_data = 32'h1234_5678;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    a_req_valid = 4'b0110;
    applyStimulus();
    checkEq("t4_words", 32'(a_words.size()), 32'd2);
    applyStimulus();
    checkEq("t4_next_gnt", 32'(a_gnt), 32'h2);
    applyStimulus();

    $display("[TB] reset mid-burst");
    a_req_valid = '0;
    resetA();
    a_words.delete();
    a_req_valid = 4'b0010;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    a_wrst = 1'b1;
    applyStimulus();
    a_wrst = 1'b0;
    checkEq("t5_words", 32'(a_words.size()), 32'd2);
    checkEq("t5_gnt_after_rst", 32'(a_gnt), 32'h0);
    checkEq("t5_busy_after_rst", 32'(a_busy), 32'h0);
    a_req_valid = 4'b0011;
    applyStimulus();
    checkEq("t5_first_gnt", 32'(a_gnt), 32'h1);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      a_wrst = ($urandom_range(0, 63) == 0);
      a_req_valid = 4'($urandom);
      a_req_data = $urandom;
      a_wfull = ($urandom_range(0, 3) == 0);
      b_wrst = ($urandom_range(0, 63) == 0);
      b_req_valid = 2'($urandom);
      b_req_data = 16'($urandom);
      b_wfull = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
